// File: rtl/rot_pkg.sv
// Shared constants for the rotary encoder input path.
// Default sizes here are also used by the downstream decoder stage.
package rot_pkg;

    localparam int ROT_GLITCH_W      = 16;
    localparam int ROT_SYNC_STAGES   = 2;
    localparam int ROT_STABLE_CYCLES = 50000;
    localparam int ROT_CNT_W         = 16;

    // Accumulate 0..2 aborts per cycle, pinning at all-ones.
    function automatic logic [ROT_GLITCH_W-1:0] rot_sat_add(
        input logic [ROT_GLITCH_W-1:0] acc,
        input logic [1:0]              inc
    );
        logic [ROT_GLITCH_W:0] sum;
        sum = {1'b0, acc} + (ROT_GLITCH_W + 1)'(inc);
        return sum[ROT_GLITCH_W] ? '1 : sum[ROT_GLITCH_W-1:0];
    endfunction

endpackage

// File: rtl/rot_chan_filter.sv
// One quadrature channel: synchronizer chain, stability counter,
// registered clean level, change strobe and abort (glitch) pulse.
module rot_chan_filter
    import rot_pkg::*;
#(
    parameter int   SYNC_STAGES   = ROT_SYNC_STAGES,
    parameter int   STABLE_CYCLES = ROT_STABLE_CYCLES,
    parameter int   CNT_W         = ROT_CNT_W,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic clean,
    output logic edge_pulse,
    output logic abort
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   edge_q, edge_d;
    logic                   s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        s       = sync_q[SYNC_STAGES-1];
        cnt_d   = '0;
        clean_d = clean_q;
        edge_d  = 1'b0;
        abort   = (cnt_q != '0) && (s == clean_q);
        // A mismatch that survives the full window is accepted.
        if (s != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = s;
                edge_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q   <= '0;
            clean_q <= INIT_LEVEL;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            edge_q  <= edge_d;
        end
    end

    assign clean      = clean_q;
    assign edge_pulse = edge_q;

endmodule

// File: rtl/rot_input_filter.sv
// Debounced quadrature front end for the rotary encoder (two channels).
// Define ROT_FILTER_GLITCH_COUNT_EN to add the saturating glitch_count port.
module rot_input_filter
    import rot_pkg::*;
#(
    parameter int   SYNC_STAGES   = ROT_SYNC_STAGES,
    parameter int   STABLE_CYCLES = ROT_STABLE_CYCLES,
    parameter int   CNT_W         = ROT_CNT_W,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ROT_A,
    input  logic ROT_B,
    output logic rot_a_clean,
    output logic rot_b_clean,
    output logic a_edge,
    output logic b_edge
`ifdef ROT_FILTER_GLITCH_COUNT_EN
    ,
    output logic [ROT_GLITCH_W-1:0] glitch_count
`endif
);

    logic a_abort;
    logic b_abort;

    rot_chan_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W),
        .INIT_LEVEL   (INIT_LEVEL)
    ) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (ROT_A),
        .clean     (rot_a_clean),
        .edge_pulse(a_edge),
        .abort     (a_abort)
    );

    rot_chan_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W),
        .INIT_LEVEL   (INIT_LEVEL)
    ) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (ROT_B),
        .clean     (rot_b_clean),
        .edge_pulse(b_edge),
        .abort     (b_abort)
    );

`ifdef ROT_FILTER_GLITCH_COUNT_EN
    logic [ROT_GLITCH_W-1:0] glitch_q, glitch_d;

    always_comb begin
        glitch_d = rot_sat_add(glitch_q, {1'b0, a_abort} + {1'b0, b_abort});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = a_abort ^ b_abort;
`endif

endmodule
